fetch_queue: RTL

//  Instruction fetch stage feeding the single-cycle CPU datapath.
//  - Issues word fetches to a variable-latency instruction memory.
//  - Buffers the returned words with their PCs in a small FIFO.
//  - Presents instructions to decode over a valid/ready handshake.
//  - On a branch/jump redirect, flushes the FIFO, drops any in-flight response and restarts at the new PC.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, the decode handshake
// and the branch/jump redirect request.
interface fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: one outstanding request to a variable-latency memory,
// returned words buffered with their PCs in a small FIFO, flushed on redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]       state, state_n;
    logic [31:0]      fetch_pc, fetch_pc_n;
    logic [31:0]      req_pc;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             mem_req_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             granted, push, pop, empty;

    assign empty   = (count == '0);
    assign granted = (state == S_FETCH) && mem_req_q && bus.mem_gnt;
    assign push    = (state == S_WAIT) && bus.mem_rvalid && !bus.redirect;
    assign pop     = bus.inst_ready && !empty && !bus.redirect;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;
        count_n    = count + CNT_W'(push) - CNT_W'(pop);

        case (state)
            S_FETCH: begin
                if (granted) begin
                    state_n    = S_WAIT;
                    fetch_pc_n = fetch_pc + 32'd4;
                end
            end
            S_WAIT, S_DISCARD: begin
                if (bus.mem_rvalid)
                    state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase

        if (push)
            wr_ptr_n = wr_ptr + PTR_W'(1);
        if (pop)
            rd_ptr_n = rd_ptr + PTR_W'(1);

        // A redirect wins over everything; a request already granted must have its response dropped.
        if (bus.redirect) begin
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
            fetch_pc_n = bus.redirect_pc & 32'hFFFF_FFFC;
            if (state == S_FETCH)
                state_n = granted ? S_DISCARD : S_FETCH;
            else
                state_n = bus.mem_rvalid ? S_FETCH : S_DISCARD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            if (granted)
                req_pc <= fetch_pc;
            // A slot is reserved for every issued request, so issue only while room remains.
            mem_req_q  <= (state_n == S_FETCH) && (count_n < FULL);
            mem_addr_q <= fetch_pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.mem_rdata;
            pc_mem[wr_ptr]   <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            assert (count < FULL);
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = !empty;
    assign bus.inst_data  = empty ? 32'd0 : data_mem[rd_ptr];
    assign bus.inst_pc    = empty ? 32'd0 : pc_mem[rd_ptr];
endmodule
